pipelined_memory: RTL and testbench

Parametrised byte-addressed, little-endian simulation memory serving the core's instruction-fetch and data-fetch paths, plus one write path. It replaces the always-ready combinational model with valid/ready request handshakes, a configurable pipelined read latency, a multi-cycle write FSM and out-of-range error reporting, so the pipeline can be exercised against realistic memory stalls.

---
 rtl/pipelined_memory.sv | 210 +++++++++++++++++++++
 tb/tb_pipelined_memory.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_memory.sv
// Byte-addressed little-endian memory with two pipelined read ports and a write FSM.
// Optional PIPELINED_MEMORY_CLEAR_EN zeroes the array word by word after reset.
module pipelined_memory #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [63:0] MEM_BYTE_SIZE = 64'h1000,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 2,
    localparam int DATA_BYTE_SIZE      = DATA_WIDTH / 8,
    localparam int DATA_INDEXING_WIDTH = $clog2(DATA_BYTE_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_valid,
    output logic                         instr_req_ready,
    input  logic [ADDR_WIDTH-1:0]        instr_addr,
    output logic                         instr_resp_valid,
    output logic [DATA_WIDTH-1:0]        instr_resp_data,
    output logic                         instr_resp_error,
    input  logic                         fetch_req_valid,
    output logic                         fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr,
    output logic                         fetch_resp_valid,
    output logic [DATA_WIDTH-1:0]        fetch_resp_data,
    output logic                         fetch_resp_error,
    input  logic                         write_valid,
    output logic                         write_ready,
    input  logic [ADDR_WIDTH-1:0]        write_addr,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [DATA_INDEXING_WIDTH:0] bytes_to_write,
    output logic                         write_done,
    output logic                         write_error
);

    localparam int MEM_BYTES = int'(MEM_BYTE_SIZE);
    localparam int IDX_W     = $clog2(MEM_BYTES);
    localparam int CW        = DATA_INDEXING_WIDTH + 1;
    localparam int CNT_W     = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH + 1)'(MEM_BYTE_SIZE);

`ifdef PIPELINED_MEMORY_CLEAR_EN
    localparam int WORDS = MEM_BYTES / DATA_BYTE_SIZE;
    localparam int CLR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR} state_t;
    localparam state_t RST_STATE = S_CLEAR;
    logic [CLR_W-1:0] clr_q, clr_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif

    logic [7:0]            mem_q [MEM_BYTES];
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [CW-1:0]         wc_q, wc_d;
    logic                  wr_oob;
    logic                  commit;
    logic                  req_ready;

    assign instr_req_ready = req_ready;
    assign fetch_req_ready = req_ready;

    // Write FSM next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        wc_d        = wc_q;
        write_ready = (state_q == S_IDLE);
        write_done  = 1'b0;
        write_error = 1'b0;
        req_ready   = 1'b1;
        wr_oob      = ({1'b0, wa_q} + (ADDR_WIDTH + 1)'(wc_q)) > MEM_LIM;
`ifdef PIPELINED_MEMORY_CLEAR_EN
        clr_d       = clr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (write_valid) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                    wa_d    = write_addr;
                    wd_d    = write_data;
                    wc_d    = (bytes_to_write > CW'(DATA_BYTE_SIZE)) ?
                              CW'(DATA_BYTE_SIZE) : bytes_to_write;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    write_done  = 1'b1;
                    write_error = wr_oob;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef PIPELINED_MEMORY_CLEAR_EN
            S_CLEAR: begin
                req_ready = 1'b0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == CLR_W'(WORDS - 1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        commit = write_done && !write_error && !rst;
    end

    // Write FSM registers; reset drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wc_q    <= '0;
`ifdef PIPELINED_MEMORY_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wc_q    <= wc_d;
`ifdef PIPELINED_MEMORY_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Storage array: not reset, so contents survive rst
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < DATA_BYTE_SIZE; i++) begin
                if (CW'(i) < wc_q)
                    mem_q[wa_q[IDX_W-1:0] + IDX_W'(i)] <= wd_q[8*i +: 8];
            end
        end
`ifdef PIPELINED_MEMORY_CLEAR_EN
        if (state_q == S_CLEAR && !rst) begin
            for (int i = 0; i < DATA_BYTE_SIZE; i++)
                mem_q[(IDX_W'(clr_q) << DATA_INDEXING_WIDTH) + IDX_W'(i)] <= '0;
        end
`endif
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                    rq_v;
        logic [ADDR_WIDTH-1:0]   rq_a;
        logic                    acc;
        logic                    oob;
        logic [ADDR_WIDTH:0]     last;
        logic [DATA_WIDTH-1:0]   word;
        logic [READ_LATENCY-1:0] v_q, v_d, e_q, e_d;
        logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY];
        logic [DATA_WIDTH-1:0]   d_d [READ_LATENCY];

        assign rq_v = (p == 0) ? instr_req_valid : fetch_req_valid;
        assign rq_a = (p == 0) ? instr_addr : fetch_addr;

        // Sample the array for the request being accepted this edge
        always_comb begin
            acc  = rq_v && req_ready;
            last = {1'b0, rq_a} + (ADDR_WIDTH + 1)'(DATA_BYTE_SIZE);
            oob  = last > MEM_LIM;
            word = '0;
            if (!oob) begin
                for (int i = 0; i < DATA_BYTE_SIZE; i++)
                    word[8*i +: 8] = mem_q[rq_a[IDX_W-1:0] + IDX_W'(i)];
            end
        end

        // Latency shift register for valid, error and data
        always_comb begin
            v_d[0] = acc;
            e_d[0] = acc && oob;
            d_d[0] = acc ? word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_d[i] = v_q[i-1];
                e_d[i] = e_q[i-1];
                d_d[i] = d_q[i-1];
            end
        end

        // Response pipeline registers; reset flushes in-flight reads
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
                e_q <= '0;
                for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= '0;
            end else begin
                v_q <= v_d;
                e_q <= e_d;
                for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= d_d[i];
            end
        end
    end

    assign instr_resp_valid = g_rd[0].v_q[READ_LATENCY-1];
    assign instr_resp_error = g_rd[0].e_q[READ_LATENCY-1];
    assign instr_resp_data  = g_rd[0].d_q[READ_LATENCY-1];
    assign fetch_resp_valid = g_rd[1].v_q[READ_LATENCY-1];
    assign fetch_resp_error = g_rd[1].e_q[READ_LATENCY-1];
    assign fetch_resp_data  = g_rd[1].d_q[READ_LATENCY-1];

endmodule

// File: tb/tb_pipelined_memory.sv
// Self-checking bench for pipelined_memory: directed cases plus random
// traffic checked every cycle against a byte-array reference model.
module tb_pipelined_memory;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NB   = 4;
    localparam int RL   = 2;
    localparam int WL   = 2;
    localparam int MEMB = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          iv, fv, wv;
    logic [AW-1:0] ia, fa, wadr;
    logic [DW-1:0] wdat_in;
    logic [2:0]    wcnt_in;
    logic          i_rdy, f_rdy, i_rv, f_rv, i_re, f_re;
    logic [DW-1:0] i_rd, f_rd;
    logic          w_rdy, w_done, w_err;

    always #5 clk = ~clk;

    pipelined_memory #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTE_SIZE(64'h1000),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_req_valid(iv), .instr_req_ready(i_rdy), .instr_addr(ia),
        .instr_resp_valid(i_rv), .instr_resp_data(i_rd), .instr_resp_error(i_re),
        .fetch_req_valid(fv), .fetch_req_ready(f_rdy), .fetch_addr(fa),
        .fetch_resp_valid(f_rv), .fetch_resp_data(f_rd), .fetch_resp_error(f_re),
        .write_valid(wv), .write_ready(w_rdy), .write_addr(wadr),
        .write_data(wdat_in), .bytes_to_write(wcnt_in),
        .write_done(w_done), .write_error(w_err)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
        bit          known;
    } rsp_t;

    byte unsigned mm [MEMB];
    bit           kn [MEMB];
    rsp_t         q0 [$];
    rsp_t         q1 [$];
    int           cyc = 0;
    bit           wbusy = 0;
    int           wcommit = 0;
    longint       m_wa;
    logic [31:0]  m_wd;
    int           m_wc;
    bit           m_werr;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [31:0]  last_d [2];
    logic         last_e [2];
    int           done_cnt = 0;
    int           werr_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic rsp_t model_read(longint a, int due);
        rsp_t r;
        r.due   = due;
        r.err   = (a + NB) > MEMB;
        r.data  = '0;
        r.known = 1'b1;
        if (!r.err) begin
            for (int i = 0; i < NB; i++) begin
                r.data[8*i +: 8] = mm[a + i];
                if (!kn[a + i]) r.known = 1'b0;
            end
        end
        return r;
    endfunction

    // Reference model: advances on every rising edge using the bench's own inputs
    always @(posedge clk) begin
        bit was;
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            wbusy = 1'b0;
        end else begin
            longint a;
            if (iv) begin
                a = ia;
                q0.push_back(model_read(a, cyc + RL - 1));
            end
            if (fv) begin
                a = fa;
                q1.push_back(model_read(a, cyc + RL - 1));
            end
            was = wbusy;
            if (wbusy && cyc == wcommit) begin
                if (!m_werr) begin
                    for (int i = 0; i < m_wc; i++) begin
                        mm[m_wa + i] = m_wd[8*i +: 8];
                        kn[m_wa + i] = 1'b1;
                    end
                end
                wbusy = 1'b0;
            end
            if (!was && wv) begin
                m_wa    = wadr;
                m_wd    = wdat_in;
                m_wc    = (wcnt_in > 3'(NB)) ? NB : int'(wcnt_in);
                m_werr  = (m_wa + m_wc) > MEMB;
                wcommit = cyc + WL;
                wbusy   = 1'b1;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        bit   ev;
        bit   ed;
        rsp_t r;
        ev = (q0.size() > 0) && (q0[0].due == cyc);
        chk("i_valid", 32'(i_rv), 32'(ev));
        if (ev) begin
            r = q0.pop_front();
            chk("i_error", 32'(i_re), 32'(r.err));
            if (r.err || r.known) chk("i_data", i_rd, r.data);
            last_d[0] = i_rd;
            last_e[0] = i_re;
        end
        ev = (q1.size() > 0) && (q1[0].due == cyc);
        chk("f_valid", 32'(f_rv), 32'(ev));
        if (ev) begin
            r = q1.pop_front();
            chk("f_error", 32'(f_re), 32'(r.err));
            if (r.err || r.known) chk("f_data", f_rd, r.data);
            last_d[1] = f_rd;
            last_e[1] = f_re;
        end
        ed = wbusy && (cyc == wcommit - 1);
        chk("w_done", 32'(w_done), 32'(ed));
        if (ed) chk("w_error", 32'(w_err), 32'(m_werr));
        chk("w_ready", 32'(w_rdy), 32'(!wbusy));
        chk("i_ready", 32'(i_rdy), 32'd1);
        chk("f_ready", 32'(f_rdy), 32'd1);
        if (w_done) done_cnt++;
        if (w_done && w_err) werr_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        iv = 0; fv = 0; wv = 0;
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d, logic [2:0] c);
        wv = 1; wadr = a; wdat_in = d; wcnt_in = c;
        tick();
        wv = 0;
        repeat (WL + 1) tick();
    endtask

    task automatic do_read(int port, logic [31:0] a);
        if (port == 0) begin iv = 1; ia = a; end
        else begin fv = 1; fa = a; end
        tick();
        iv = 0; fv = 0;
        repeat (RL + 1) tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0, 1, 2, 3, 4: return 32'($urandom % 64);
            5, 6:          return 32'(MEMB - 8 + ($urandom % 8));
            default:       return 32'hFFFF_FFF0 + 32'($urandom % 16);
        endcase
    endfunction

    initial begin
        int d0, e0;
        rst = 1; idle_in();
        ia = '0; fa = '0; wadr = '0; wdat_in = '0; wcnt_in = '0;
        repeat (2) tick();
        chk("rst_data", i_rd, 32'h0);
        chk("rst_ready", 32'(w_rdy), 32'd1);
        rst = 0;
        tick();

        do_write(32'h10, 32'hDEADBEEF, 3'd4);
        do_read(0, 32'h10);
        chk("lit_deadbeef", last_d[0], 32'hDEADBEEF);
        chk("lit_deadbeef_err", 32'(last_e[0]), 32'd0);

        do_write(32'h10, 32'h11223344, 3'd2);
        do_read(0, 32'h10);
        chk("lit_partial", last_d[0], 32'hDEAD3344);
        d0 = done_cnt;
        do_write(32'h10, 32'hFFFFFFFF, 3'd0);
        chk("cnt0_done", 32'(done_cnt - d0), 32'd1);
        do_read(1, 32'h10);
        chk("lit_cnt0", last_d[1], 32'hDEAD3344);
        chk("model_pin", model_read(64'h10, 0).data, 32'hDEAD3344);

        do_write(32'hFFC, 32'hAABBCCDD, 3'd4);
        do_read(1, 32'hFFE);
        chk("oob_err", 32'(last_e[1]), 32'd1);
        chk("oob_data", last_d[1], 32'h0);
        e0 = werr_cnt;
        do_write(32'hFFE, 32'h55667788, 3'd4);
        chk("oob_werr", 32'(werr_cnt - e0), 32'd1);
        do_read(0, 32'hFFC);
        chk("oob_neigh", last_d[0], 32'hAABBCCDD);

        for (int i = 0; i < 3; i++) begin
            iv = 1; fv = 1; ia = 32'(4 * i); fa = 32'(4 * i);
            tick();
        end
        idle_in();
        repeat (RL + 1) tick();

        do_write(32'h20, 32'h01234567, 3'd4);
        wv = 1; wadr = 32'h20; wdat_in = 32'h89ABCDEF; wcnt_in = 3'd4;
        tick();
        wv = 0;
        tick();
        iv = 1; ia = 32'h20;
        tick();
        ia = 32'h20;
        tick();
        iv = 0;
        chk("commit_old", last_d[0], 32'h01234567);
        tick();
        chk("commit_new", last_d[0], 32'h89ABCDEF);
        repeat (2) tick();

        do_write(32'h40, 32'hCAFEF00D, 3'd4);
        d0 = done_cnt;
        wv = 1; wadr = 32'h40; wdat_in = 32'h12345678; wcnt_in = 3'd4;
        tick();
        wv = 0; rst = 1;
        tick();
        rst = 0;
        repeat (3) tick();
        chk("rst_nodone", 32'(done_cnt - d0), 32'd0);
        do_read(0, 32'h40);
        chk("rst_keep", last_d[0], 32'hCAFEF00D);

        for (int n = 0; n < 3000; n++) begin
            iv = ($urandom % 2) == 0;
            fv = ($urandom % 2) == 0;
            ia = rand_addr();
            fa = rand_addr();
            wv = ($urandom % 3) == 0;
            wadr = rand_addr();
            wdat_in = $urandom;
            wcnt_in = 3'($urandom_range(0, 7));
            rst = ($urandom % 300) == 0;
            tick();
        end
        idle_in();
        rst = 0;
        repeat (RL + WL + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
